csr_row_scheduler: RTL

- Sequences the sparse matrix-vector datapath for a CSR-encoded matrix.
- On `start`, reads the row-pointer memory to find each row's nonzero range.
- Streams one nonzero index per handshake to the MAC datapath, tagged with its row and a row-end marker.
- Sits between the top-level control and the value/column-index fetch plus MAC pipeline.

---
 rtl/csr_row_scheduler_pkg.sv | 22 ++
 rtl/csr_row_scheduler_if.sv | 35 +++
 rtl/csr_row_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/csr_row_scheduler_pkg.sv
// Shared types for the sparse matrix-vector pipeline.
// Scheduler state codes and the element bundle passed to fetch/MAC.
package sparse_pkg;

    localparam int ROW_W_DEF = 16;
    localparam int NNZ_W_DEF = 20;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_LO = 3'd1;
    localparam logic [2:0] ST_LOAD_HI = 3'd2;
    localparam logic [2:0] ST_STREAM  = 3'd3;
    localparam logic [2:0] ST_EMPTY   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef struct packed {
        logic [NNZ_W_DEF-1:0] idx;
        logic [ROW_W_DEF-1:0] row;
        logic                 last;
        logic                 empty;
    } elem_t;

endpackage

// File: rtl/csr_row_scheduler_if.sv
// Element stream from the row scheduler to the value/col fetch stage.
// Valid/ready handshake; payload is held while stalled.
interface csr_row_scheduler_if
    import sparse_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int NNZ_W = NNZ_W_DEF
);

    logic             elem_valid;
    logic             elem_ready;
    logic [NNZ_W-1:0] elem_idx;
    logic [ROW_W-1:0] elem_row;
    logic             elem_last;
    logic             elem_empty;

    modport master (
        output elem_valid,
        output elem_idx,
        output elem_row,
        output elem_last,
        output elem_empty,
        input  elem_ready
    );

    modport slave (
        input  elem_valid,
        input  elem_idx,
        input  elem_row,
        input  elem_last,
        input  elem_empty,
        output elem_ready
    );

endinterface

// File: rtl/csr_row_scheduler.sv
// Walks the CSR row-pointer array and streams one nonzero index per
// handshake, tagged with row and row-end, to the fetch/MAC pipeline.
module csr_row_scheduler
    import sparse_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int NNZ_W = NNZ_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROW_W-1:0]   num_rows,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ptr_rd_en,
    output logic [ROW_W:0]     ptr_rd_addr,
    input  logic [NNZ_W-1:0]   ptr_rd_data,
    csr_row_scheduler_if.master elem
);

    localparam logic [ROW_W:0]   ADDR_ONE = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [ROW_W:0]   ADDR_TWO = {{(ROW_W-1){1'b0}}, 2'b10};
    localparam logic [ROW_W-1:0] ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [NNZ_W-1:0] NNZ_ONE  = {{(NNZ_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [NNZ_W-1:0] lo_q, lo_d;
    logic [NNZ_W-1:0] hi_q, hi_d;
    logic [NNZ_W-1:0] cur_q, cur_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] nrows_q, nrows_d;
    logic             err_q, err_d;

    logic             valid;
    logic             in_stream;
    logic             in_empty;
    logic             last_el;
    logic             hs;

    assign in_stream = (state_q == ST_STREAM);
    assign in_empty  = (state_q == ST_EMPTY);
    assign valid     = in_stream | in_empty;
    assign last_el   = in_empty | (in_stream & (cur_q == hi_q - NNZ_ONE));
    assign hs        = valid & elem.elem_ready;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cur_d       = cur_q;
        row_d       = row_q;
        nrows_d     = nrows_q;
        err_d       = err_q;
        ptr_rd_en   = 1'b0;
        ptr_rd_addr = '0;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_rows == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        nrows_d     = num_rows;
                        row_d       = '0;
                        ptr_rd_en   = 1'b1;
                        ptr_rd_addr = '0;
                        state_d     = ST_LOAD_LO;
                    end
                end
            end
            ST_LOAD_LO: begin
                lo_d        = ptr_rd_data;
                ptr_rd_en   = 1'b1;
                ptr_rd_addr = {1'b0, row_q} + ADDR_ONE;
                state_d     = ST_LOAD_HI;
            end
            ST_LOAD_HI: begin
                hi_d  = ptr_rd_data;
                cur_d = lo_q;
                if (ptr_rd_data > lo_q) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_EMPTY;
                end
                if (ptr_rd_data < lo_q) begin
                    err_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (hs && !last_el) begin
                    cur_d = cur_q + NNZ_ONE;
                end
            end
            ST_EMPTY: begin
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Row end: the next row's low pointer is this row's high pointer,
        // so only entry row+2 needs fetching.
        if (hs && last_el) begin
            if (row_q == nrows_q - ROW_ONE) begin
                state_d = ST_DONE;
            end else begin
                lo_d        = hi_q;
                row_d       = row_q + ROW_ONE;
                ptr_rd_en   = 1'b1;
                ptr_rd_addr = {1'b0, row_q} + ADDR_TWO;
                state_d     = ST_LOAD_HI;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            cur_q   <= '0;
            row_q   <= '0;
            nrows_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cur_q   <= cur_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
            err_q   <= err_d;
        end
    end

    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign err             = err_q;
    assign elem.elem_valid = valid;
    assign elem.elem_idx   = in_stream ? cur_q : '0;
    assign elem.elem_row   = valid ? row_q : '0;
    assign elem.elem_last  = valid & last_el;
    assign elem.elem_empty = in_empty;

endmodule
